rgb_pair_writer: RTL and testbench
==================================

# rgb_pair_writer

Colour-space conversion and write-back stage for milestone 1 of the image decompressor. Accepts upsampled YUV pixel pairs (even/odd pixel of one row) from the upsampling datapath, converts them to 8-bit RGB with fixed-point BT.601 coefficients, and writes the pair as three packed 16-bit words into the RGB region of external SRAM. It is the last stage before SRAM, so every word it writes is final and is checked word-for-word by the project testbench.

## Interface

- Parameters
- RGB_BASE, 18'd146944, SRAM word address of the first RGB word of the frame
- NUM_PAIRS, 38400, pixel pairs per frame (320*240/2)
- Ports (single clock; reset is asynchronous and active-low)
- Clock  input  1  50 MHz system clock; all state changes on rising edge
- Resetn  input  1  asynchronous active-low reset
- start  input  1  one-cycle pulse; begins a frame (ignored while busy=1)
- pair_valid  input  1  Y0,Y1,U0,U1,V0,V1 hold a valid pair
- pair_ready  output  1  block accepts a pair this cycle
- Y0, Y1, U0, U1, V0, V1  input  8 each  unsigned pixel components (even = 0, odd = 1)
- SRAM_address  output  18  write address
- SRAM_write_data  output  16  packed RGB word
- SRAM_we_n  output  1  active-low write enable
- busy  output  1  frame in progress
- done  output  1  one-cycle pulse after the last word of the frame is written

## Operation

- States: S_IDLE, S_CALC, S_W0, S_W1, S_W2.
- Not busy: pair_ready=0; start sets busy=1, word address pointer = RGB_BASE, pair count = 0, stays S_IDLE.
- S_IDLE with busy=1: pair_ready=1; pair_valid&&pair_ready latches the six inputs, -> S_CALC.
- S_CALC: compute R,G,B for both pixels, register results, -> S_W0.
- S_W0: write {R0,G0} at pointer; S_W1: {B0,R1} at pointer+1; S_W2: {G1,B1} at pointer+2; pointer += 3 on leaving S_W2.
- S_W2: pair_ready=1 unless this is pair NUM_PAIRS-1; accept -> S_CALC, else -> S_IDLE.
- Last pair: after S_W2 -> S_IDLE, busy=0, done=1 for exactly one cycle, pair_ready=0 until next start.
- Arithmetic (per pixel, 32-bit signed): y=Y-16, u=U-128, v=V-128 (9-bit signed);
- R = 76284*y + 104595*v; G = 76284*y - 25624*u - 53281*v; B = 76284*y + 132251*u.
- Result = acc >>> 16 (arithmetic); clip: negative -> 0, >255 -> 255, else bits [7:0].
- Inputs are not used after the S_CALC latch; upstream may change them once pair_ready&&pair_valid has been seen.
- start while busy=1: ignored, no state change.

## Timing

- Reset values: SRAM_address=0, SRAM_write_data=0, SRAM_we_n=1, pair_ready=0, busy=0, done=0, state S_IDLE, pointer=RGB_BASE, count=0.
- All outputs registered or decoded from registered state; no combinational path from pair_valid to any output.
- Latency: acceptance edge -> S_CALC (1 cycle) -> first SRAM_we_n=0 cycle is the 2nd cycle after acceptance; three consecutive write cycles with address/data stable for the whole cycle.
- Sustained throughput: one pair per 4 cycles (accept in S_W2 -> S_CALC).
- SRAM_we_n=1 in S_IDLE and S_CALC; no address is written twice per frame; exactly 3*NUM_PAIRS writes per frame covering RGB_BASE .. RGB_BASE+3*NUM_PAIRS-1.
- Resetn asserted mid-frame: immediate return to reset values; in-flight pair discarded, no further write.

## Test plan

- Reset then idle: no start, pair_valid=1 for 20 cycles -> pair_ready=0, SRAM_we_n=1 throughout.
- Black/white pair: start; Y0=16,Y1=235,U=V=128 -> writes 0x0000 @146944, 0x00FE @146945, 0xFEFE @146946; first we_n=0 two cycles after acceptance.
- Clipping: Y0=255,U0=V0=128; Y1=16,U1=128,V1=255 -> R0=G0=B0=255, R1=202,G1=0,B1=0 -> words 0xFFFF, 0xFFCA, 0x0000.
- Back-to-back: pair_valid held high with NUM_PAIRS=4 -> pairs accepted every 4 cycles, 12 writes at RGB_BASE..+11, one done pulse, busy falls with done, pair_ready=0 afterwards.
- Upstream stall: drop pair_valid for 7 cycles between pairs -> block waits in S_IDLE, no writes, addresses remain contiguous.
- Reset mid-frame: assert Resetn=0 during S_W1 -> we_n=1 next cycle, all outputs at reset values; new start restarts at RGB_BASE.

Source files
------------

// File: rtl/rgb_pair_writer.sv
// Colour-space conversion and SRAM write-back for upsampled YUV pixel pairs.
// Each accepted pair is converted to RGB and written as three packed 16-bit words.
module rgb_pair_writer #(
  parameter logic [17:0] RGB_BASE  = 18'd146944,
  parameter int unsigned NUM_PAIRS = 38400
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic        start,
  input  logic        pair_valid,
  output logic        pair_ready,
  input  logic [7:0]  Y0,
  input  logic [7:0]  Y1,
  input  logic [7:0]  U0,
  input  logic [7:0]  U1,
  input  logic [7:0]  V0,
  input  logic [7:0]  V1,
  output logic [17:0] SRAM_address,
  output logic [15:0] SRAM_write_data,
  output logic        SRAM_we_n,
  output logic        busy,
  output logic        done
);

  localparam int unsigned CNT_W = $clog2(NUM_PAIRS + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_PAIRS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CALC,
    S_W0,
    S_W1,
    S_W2
  } state_t;

  state_t           state_q, state_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [17:0]      ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // {Y0,U0,V0,Y1,U1,V1} and {R0,G0,B0,R1,G1,B1}
  logic [47:0]      yuv_q, yuv_d;
  logic [47:0]      rgb_q, rgb_d;

  logic last_pair;
  logic accept;

  function automatic logic [7:0] clip8(input logic signed [31:0] acc);
    logic signed [31:0] s;
    s = acc >>> 16;
    if (s < 32'sd0) return 8'd0;
    if (s > 32'sd255) return 8'hFF;
    return s[7:0];
  endfunction

  function automatic logic [23:0] yuv2rgb(input logic [7:0] yi, input logic [7:0] ui,
                                          input logic [7:0] vi);
    logic signed [31:0] y, u, v, r, g, b;
    y = $signed({24'd0, yi}) - 32'sd16;
    u = $signed({24'd0, ui}) - 32'sd128;
    v = $signed({24'd0, vi}) - 32'sd128;
    r = 32'sd76284 * y + 32'sd104595 * v;
    g = 32'sd76284 * y - 32'sd25624 * u - 32'sd53281 * v;
    b = 32'sd76284 * y + 32'sd132251 * u;
    return {clip8(r), clip8(g), clip8(b)};
  endfunction

  assign last_pair  = (cnt_q == LAST_IDX);
  assign pair_ready = busy_q && ((state_q == S_IDLE) || ((state_q == S_W2) && !last_pair));
  assign accept     = pair_valid && pair_ready;
  assign busy       = busy_q;
  assign done       = done_q;

  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    yuv_d   = yuv_q;
    rgb_d   = rgb_q;
    case (state_q)
      S_IDLE: begin
        if (!busy_q) begin
          if (start) begin
            busy_d = 1'b1;
            ptr_d  = RGB_BASE;
            cnt_d  = '0;
          end
        end else if (accept) begin
          yuv_d   = {Y0, U0, V0, Y1, U1, V1};
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        rgb_d   = {yuv2rgb(yuv_q[47:40], yuv_q[39:32], yuv_q[31:24]),
                   yuv2rgb(yuv_q[23:16], yuv_q[15:8], yuv_q[7:0])};
        state_d = S_W0;
      end
      S_W0: state_d = S_W1;
      S_W1: state_d = S_W2;
      S_W2: begin
        ptr_d = ptr_q + 18'd3;
        if (last_pair) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (accept) begin
            yuv_d   = {Y0, U0, V0, Y1, U1, V1};
            state_d = S_CALC;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Write port decoded from registered state so address/data hold for the whole cycle.
  always_comb begin
    SRAM_we_n       = 1'b1;
    SRAM_address    = '0;
    SRAM_write_data = '0;
    case (state_q)
      S_W0: begin
        SRAM_we_n       = 1'b0;
        SRAM_address    = ptr_q;
        SRAM_write_data = rgb_q[47:32];
      end
      S_W1: begin
        SRAM_we_n       = 1'b0;
        SRAM_address    = ptr_q + 18'd1;
        SRAM_write_data = rgb_q[31:16];
      end
      S_W2: begin
        SRAM_we_n       = 1'b0;
        SRAM_address    = ptr_q + 18'd2;
        SRAM_write_data = rgb_q[15:0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ptr_q   <= RGB_BASE;
      cnt_q   <= '0;
      yuv_q   <= '0;
      rgb_q   <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      yuv_q   <= yuv_d;
      rgb_q   <= rgb_d;
    end
  end

endmodule

// File: tb/tb_rgb_pair_writer.sv
// Bench for rgb_pair_writer: directed frames checked against a per-cycle
// model of expected SRAM writes, acceptance spacing and done pulses.
module tb_rgb_pair_writer;

  localparam logic [17:0] BASE = 18'd146944;
  localparam int NP = 4;

  logic        Clock = 1'b0;
  logic        Resetn, start, pair_valid, pair_ready;
  logic [7:0]  Y0, Y1, U0, U1, V0, V1;
  logic [17:0] SRAM_address;
  logic [15:0] SRAM_write_data;
  logic        SRAM_we_n, busy, done;

  always #10 Clock = ~Clock;

  rgb_pair_writer #(.RGB_BASE(BASE), .NUM_PAIRS(NP)) dut (
    .Clock(Clock), .Resetn(Resetn), .start(start), .pair_valid(pair_valid),
    .pair_ready(pair_ready), .Y0(Y0), .Y1(Y1), .U0(U0), .U1(U1), .V0(V0), .V1(V1),
    .SRAM_address(SRAM_address), .SRAM_write_data(SRAM_write_data),
    .SRAM_we_n(SRAM_we_n), .busy(busy), .done(done)
  );

  typedef struct {
    int cyc;
    int addr;
    int data;
  } wr_t;

  wr_t exp_q[$];
  int  n_assert = 0;
  int  n_fail = 0;
  int  cyc = 0;
  int  done_cyc = -1;
  int  frame_pairs = 0;
  int  done_count = 0;
  int  last_acc = -1;
  bit  acc_flag = 0;
  bit  b2b = 0;
  int  w0, w1, w2;

  task automatic chk(input string name, input int act, input int req);
    n_assert++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic int clip(input int acc);
    int s;
    s = acc >>> 16;
    if (s < 0) return 0;
    if (s > 255) return 255;
    return s;
  endfunction

  task automatic model_words(input int y0, input int u0, input int v0,
                             input int y1, input int u1, input int v1,
                             output int o0, output int o1, output int o2);
    int r0, g0, b0, r1, g1, b1;
    r0 = clip(76284 * (y0 - 16) + 104595 * (v0 - 128));
    g0 = clip(76284 * (y0 - 16) - 25624 * (u0 - 128) - 53281 * (v0 - 128));
    b0 = clip(76284 * (y0 - 16) + 132251 * (u0 - 128));
    r1 = clip(76284 * (y1 - 16) + 104595 * (v1 - 128));
    g1 = clip(76284 * (y1 - 16) - 25624 * (u1 - 128) - 53281 * (v1 - 128));
    b1 = clip(76284 * (y1 - 16) + 132251 * (u1 - 128));
    o0 = r0 * 256 + g0;
    o1 = b0 * 256 + r1;
    o2 = g1 * 256 + b1;
  endtask

  // Runs at the falling edge, where every DUT output and bench input is stable.
  task automatic check_cycle();
    wr_t e;
    int  a0, a1, a2;
    cyc++;
    acc_flag = 0;
    if (!Resetn) begin
      exp_q.delete();
      done_cyc = -1;
      return;
    end
    if (SRAM_we_n === 1'b0) begin
      if (exp_q.size() == 0) begin
        n_assert++;
        n_fail++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, no write due (cycle %0d)",
                 SRAM_address, SRAM_write_data, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("write_cycle", cyc, e.cyc);
        chk("write_addr", int'(SRAM_address), e.addr);
        chk("write_data", int'(SRAM_write_data), e.data);
      end
    end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      e = exp_q.pop_front();
      n_assert++;
      n_fail++;
      $display("FAIL missing_write: we_n=1, expected write 0x%0h @0x%0h (cycle %0d)",
               e.data, e.addr, cyc);
    end
    chk("done", int'(done), int'(cyc == done_cyc));
    if (done) done_count++;
    if (!busy) chk("ready_when_idle", int'(pair_ready), 0);
    if (pair_valid && pair_ready) begin
      acc_flag = 1;
      if (frame_pairs >= NP) begin
        n_assert++;
        n_fail++;
        $display("FAIL accept_beyond_frame: pair %0d accepted, frame holds %0d", frame_pairs, NP);
      end
      if (b2b && last_acc >= 0) chk("accept_spacing", cyc - last_acc, 4);
      last_acc = cyc;
      model_words(int'(Y0), int'(U0), int'(V0), int'(Y1), int'(U1), int'(V1), a0, a1, a2);
      exp_q.push_back('{cyc + 2, int'(BASE) + 3 * frame_pairs, a0});
      exp_q.push_back('{cyc + 3, int'(BASE) + 3 * frame_pairs + 1, a1});
      exp_q.push_back('{cyc + 4, int'(BASE) + 3 * frame_pairs + 2, a2});
      frame_pairs++;
      if (frame_pairs == NP) done_cyc = cyc + 5;
    end
    if (start && !busy) begin
      frame_pairs = 0;
      last_acc = -1;
    end
  endtask

  task automatic tick();
    @(negedge Clock);
    check_cycle();
    @(posedge Clock);
    #2;
  endtask

  task automatic scramble();
    Y0 = 8'($urandom_range(0, 255)); U0 = 8'($urandom_range(0, 255));
    V0 = 8'($urandom_range(0, 255)); Y1 = 8'($urandom_range(0, 255));
    U1 = 8'($urandom_range(0, 255)); V1 = 8'($urandom_range(0, 255));
  endtask

  task automatic send_pair(input int a, input int b, input int c,
                           input int d, input int e, input int f);
    Y0 = 8'(a); U0 = 8'(b); V0 = 8'(c); Y1 = 8'(d); U1 = 8'(e); V1 = 8'(f);
    pair_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (acc_flag) break;
    end
    if (!acc_flag) begin
      n_assert++;
      n_fail++;
      $display("FAIL accept_timeout: pair not accepted within 40 cycles");
    end
    pair_valid = 1'b0;
    scramble();
  endtask

  task automatic wait_done(input int target);
    for (int i = 0; i < 60; i++) begin
      if (done_count >= target) break;
      tick();
    end
    chk("done_pulses", done_count, target);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    Resetn = 1'b0; start = 1'b0; pair_valid = 1'b0;
    Y0 = '0; Y1 = '0; U0 = '0; U1 = '0; V0 = '0; V1 = '0;
    repeat (3) tick();
    chk("rst_addr", int'(SRAM_address), 0);
    chk("rst_data", int'(SRAM_write_data), 0);
    chk("rst_we_n", int'(SRAM_we_n), 1);
    chk("rst_ready", int'(pair_ready), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);

    model_words(16, 128, 128, 235, 128, 128, w0, w1, w2);
    chk("model_bw_w0", w0, 'h0000);
    chk("model_bw_w1", w1, 'h00FE);
    chk("model_bw_w2", w2, 'hFEFE);
    model_words(255, 128, 128, 16, 128, 255, w0, w1, w2);
    chk("model_clip_w0", w0, 'hFFFF);
    chk("model_clip_w1", w1, 'hFFCA);
    chk("model_clip_w2", w2, 'h0000);

    Resetn = 1'b1;
    tick();

    // Idle with valid asserted and no start.
    pair_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle_ready", int'(pair_ready), 0);
      chk("idle_we_n", int'(SRAM_we_n), 1);
    end
    pair_valid = 1'b0;

    // Frame 1: black/white, clipping, upstream stall, two random pairs.
    pulse_start();
    chk("busy_after_start", int'(busy), 1);
    send_pair(16, 128, 128, 235, 128, 128);
    chk("calc_we_n", int'(SRAM_we_n), 1);
    tick();
    chk("first_we_n", int'(SRAM_we_n), 0);
    chk("first_addr", int'(SRAM_address), 146944);
    chk("first_data", int'(SRAM_write_data), 'h0000);
    send_pair(255, 128, 128, 16, 128, 255);
    repeat (4) tick();
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("stall_we_n", int'(SRAM_we_n), 1);
    end
    send_pair($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
              $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
    send_pair(200, 40, 220, 90, 180, 60);
    wait_done(1);
    chk("busy_after_done", int'(busy), 0);
    repeat (4) tick();

    // Frame 2: pair_valid held high throughout.
    b2b = 1;
    pulse_start();
    scramble();
    pair_valid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (acc_flag) scramble();
      if (done_count >= 2) break;
    end
    chk("b2b_done_pulses", done_count, 2);
    chk("b2b_pairs", frame_pairs, NP);
    chk("b2b_busy_falls", int'(busy), 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("b2b_ready_after", int'(pair_ready), 0);
    end
    pair_valid = 1'b0;
    b2b = 0;

    // Frame 3: reset during the second word of a pair.
    pulse_start();
    send_pair(100, 90, 160, 50, 200, 30);
    for (int i = 0; i < 10; i++) begin
      if (!SRAM_we_n && SRAM_address == BASE + 18'd1) break;
      tick();
    end
    chk("reached_w1_addr", int'(SRAM_address), int'(BASE) + 1);
    Resetn = 1'b0;
    #1;
    chk("mid_rst_we_n", int'(SRAM_we_n), 1);
    chk("mid_rst_addr", int'(SRAM_address), 0);
    chk("mid_rst_busy", int'(busy), 0);
    tick();
    chk("mid_rst_ready", int'(pair_ready), 0);
    Resetn = 1'b1;
    tick();
    pulse_start();
    send_pair(60, 70, 80, 140, 150, 160);
    tick();
    chk("restart_addr", int'(SRAM_address), 146944);
    repeat (6) tick();
    chk("queue_drained", exp_q.size(), 0);
    chk("total_done_pulses", done_count, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
